biquad_channel_scheduler: RTL and testbench

- Time-multiplexes one fixed-point biquad datapath (transposed direct-form II, Q-format coefficients, arithmetic shift by FRAC) across NCH EEG channels.
- One shared 32x32 signed multiplier is sequenced through the five coefficient products of each sample.
- Per-channel history (s1, s2) is held in a small register file.
- Sits between the multi-channel sample front end and the band-power stage; replaces NCH copies of the per-band filter.

---
 rtl/biquad_sched_pkg.sv | 58 +++++
 rtl/biquad_channel_scheduler_if.sv | 27 ++
 rtl/biquad_mul_acc.sv | 38 +++
 rtl/biquad_channel_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_biquad_channel_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/biquad_sched_pkg.sv
// Shared types and constants for the time-multiplexed biquad scheduler.
// Optional build macro BIQUAD_SCHED_SAT_EN selects saturating output (see sat32).
package biquad_sched_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PROD_W   = 64;
    localparam int unsigned STATE_W  = 64;
    localparam int unsigned FRAC_DEF = 27;
    localparam int unsigned NCOEF    = 5;

    // Coefficient register indices, also the cfg_addr encoding.
    localparam logic [2:0] CF_B1 = 3'd0;
    localparam logic [2:0] CF_B2 = 3'd1;
    localparam logic [2:0] CF_B3 = 3'd2;
    localparam logic [2:0] CF_A2 = 3'd3;
    localparam logic [2:0] CF_A3 = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD,
        ST_P_B1,
        ST_P_B2,
        ST_P_A2,
        ST_P_B3,
        ST_P_A3,
        ST_OUT
    } state_t;

    // Addend source for the shared multiply-accumulate.
    typedef enum logic [1:0] {
        ADD_ZERO,
        ADD_S1,
        ADD_T_S2,
        ADD_T
    } add_sel_t;

    // Operand-mux controls issued by the FSM each cycle.
    typedef struct packed {
        logic [2:0] coef_sel;
        logic       b_is_y;
        add_sel_t   add_sel;
        logic       sub;
    } mac_ctrl_t;

    // Clamp a 64-bit value into the signed 32-bit range.
    function automatic logic signed [DATA_W-1:0] sat32(input logic signed [PROD_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > 64'sh0000_0000_7FFF_FFFF) begin
            r = 32'sh7FFF_FFFF;
        end else if (v < -64'sh0000_0000_8000_0000) begin
            r = 32'sh8000_0000;
        end else begin
            r = DATA_W'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/biquad_channel_scheduler_if.sv
// Sample-in / result-out handshake bundle for the biquad channel scheduler.
interface biquad_channel_scheduler_if
    import biquad_sched_pkg::*;
#(
    parameter int unsigned CHW = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CHW-1:0]           in_ch;
    logic signed [DATA_W-1:0] in_x;
    logic                     out_valid;
    logic                     out_ready;
    logic [CHW-1:0]           out_ch;
    logic signed [DATA_W-1:0] out_y;

    // Sample source / result consumer side.
    modport master (
        output in_valid, in_ch, in_x, out_ready,
        input  in_ready, out_valid, out_ch, out_y
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_ch, in_x, out_ready,
        output in_ready, out_valid, out_ch, out_y
    );
endinterface

// File: rtl/biquad_mul_acc.sv
// Shared signed 32x32 multiplier with 64-bit add/subtract and operand muxes.
module biquad_mul_acc
    import biquad_sched_pkg::*;
(
    input  mac_ctrl_t                       i_ctrl,
    input  logic [NCOEF-1:0][DATA_W-1:0]    i_coef,
    input  logic signed [DATA_W-1:0]        i_x,
    input  logic signed [DATA_W-1:0]        i_y,
    input  logic signed [STATE_W-1:0]       i_s1,
    input  logic signed [STATE_W-1:0]       i_s2,
    input  logic signed [STATE_W-1:0]       i_t,
    output logic signed [STATE_W-1:0]       o_sum_c
);
    logic signed [DATA_W-1:0]  w_op_a;
    logic signed [DATA_W-1:0]  w_op_b;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [STATE_W-1:0] w_addend;

    // Operand selection, product and wrap-around accumulate.
    always_comb begin
        case (i_ctrl.coef_sel)
            CF_B2:   w_op_a = i_coef[CF_B2];
            CF_B3:   w_op_a = i_coef[CF_B3];
            CF_A2:   w_op_a = i_coef[CF_A2];
            CF_A3:   w_op_a = i_coef[CF_A3];
            default: w_op_a = i_coef[CF_B1];
        endcase
        w_op_b = i_ctrl.b_is_y ? i_y : i_x;
        w_prod = PROD_W'(w_op_a) * PROD_W'(w_op_b);
        case (i_ctrl.add_sel)
            ADD_S1:   w_addend = i_s1;
            ADD_T_S2: w_addend = i_t + i_s2;
            ADD_T:    w_addend = i_t;
            default:  w_addend = '0;
        endcase
        o_sum_c = i_ctrl.sub ? (w_addend - w_prod) : (w_addend + w_prod);
    end
endmodule

// File: rtl/biquad_channel_scheduler.sv
// Time-multiplexed TDF-II biquad shared across NCH channels.
// Build macro BIQUAD_SCHED_SAT_EN: clamp y to signed 32 bits instead of wrapping.
module biquad_channel_scheduler
    import biquad_sched_pkg::*;
#(
    parameter int unsigned NCH     = 8,
    parameter int unsigned CHW     = 3,
    parameter int unsigned FRAC    = FRAC_DEF,
    parameter int          B1_INIT = 9426879,
    parameter int          B2_INIT = 0,
    parameter int          B3_INIT = -9426879,
    parameter int          A2_INIT = -240788605,
    parameter int          A3_INIT = 115363971
) (
    input  logic                      clk,
    input  logic                      reset,
    biquad_channel_scheduler_if.slave bus,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_addr,
    input  logic signed [DATA_W-1:0]  cfg_data,
    input  logic                      clr,
    output logic                      busy
);
    state_t                         r_state;
    state_t                         w_state_nxt;
    mac_ctrl_t                      w_ctrl;
    logic                           w_accept;
    logic                           w_clr_now;
    logic                           w_ld;
    logic                           w_y_we;
    logic                           w_t_we;
    logic                           w_s1n_we;
    logic                           w_hist_we;
    logic signed [STATE_W-1:0]      w_sum;
    logic signed [DATA_W-1:0]       w_y_c;

    logic [NCOEF-1:0][DATA_W-1:0]   r_coef;
    logic [NCOEF-1:0][DATA_W-1:0]   r_wcoef;
    logic signed [STATE_W-1:0]      r_hist_s1 [NCH];
    logic signed [STATE_W-1:0]      r_hist_s2 [NCH];
    logic signed [DATA_W-1:0]       r_x;
    logic signed [DATA_W-1:0]       r_y;
    logic [CHW-1:0]                 r_ch;
    logic signed [STATE_W-1:0]      r_s1;
    logic signed [STATE_W-1:0]      r_s2;
    logic signed [STATE_W-1:0]      r_t;
    logic signed [STATE_W-1:0]      r_s1n;
    logic                           r_clr_pend;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic [CHW-1:0]                 r_out_ch;
    logic signed [DATA_W-1:0]       r_out_y;
    logic                           r_busy;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = '{coef_sel: CF_B1, b_is_y: 1'b0, add_sel: ADD_ZERO, sub: 1'b0};
        w_accept    = 1'b0;
        w_clr_now   = 1'b0;
        w_ld        = 1'b0;
        w_y_we      = 1'b0;
        w_t_we      = 1'b0;
        w_s1n_we    = 1'b0;
        w_hist_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr_now = clr | r_clr_pend;
                if (bus.in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LD;
                end
            end
            ST_LD: begin
                w_ld        = 1'b1;
                w_state_nxt = ST_P_B1;
            end
            ST_P_B1: begin
                w_ctrl.coef_sel = CF_B1;
                w_ctrl.add_sel  = ADD_S1;
                w_y_we          = 1'b1;
                w_state_nxt     = ST_P_B2;
            end
            ST_P_B2: begin
                w_ctrl.coef_sel = CF_B2;
                w_t_we          = 1'b1;
                w_state_nxt     = ST_P_A2;
            end
            ST_P_A2: begin
                w_ctrl.coef_sel = CF_A2;
                w_ctrl.b_is_y   = 1'b1;
                w_ctrl.add_sel  = ADD_T_S2;
                w_ctrl.sub      = 1'b1;
                w_s1n_we        = 1'b1;
                w_state_nxt     = ST_P_B3;
            end
            ST_P_B3: begin
                w_ctrl.coef_sel = CF_B3;
                w_t_we          = 1'b1;
                w_state_nxt     = ST_P_A3;
            end
            ST_P_A3: begin
                w_ctrl.coef_sel = CF_A3;
                w_ctrl.b_is_y   = 1'b1;
                w_ctrl.add_sel  = ADD_T;
                w_ctrl.sub      = 1'b1;
                w_hist_we       = 1'b1;
                w_state_nxt     = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    biquad_mul_acc u_mul_acc (
        .i_ctrl  (w_ctrl),
        .i_coef  (r_wcoef),
        .i_x     (r_x),
        .i_y     (r_y),
        .i_s1    (r_s1),
        .i_s2    (r_s2),
        .i_t     (r_t),
        .o_sum_c (w_sum)
    );

    // Output sample from the P_B1 accumulator.
    always_comb begin
`ifdef BIQUAD_SCHED_SAT_EN
        w_y_c = sat32(w_sum >>> FRAC);
`else
        w_y_c = w_sum[FRAC +: DATA_W];
`endif
    end

    // Live coefficient registers; writes land in any state, 5..7 dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_coef[CF_B1] <= DATA_W'(B1_INIT);
            r_coef[CF_B2] <= DATA_W'(B2_INIT);
            r_coef[CF_B3] <= DATA_W'(B3_INIT);
            r_coef[CF_A2] <= DATA_W'(A2_INIT);
            r_coef[CF_A3] <= DATA_W'(A3_INIT);
        end else if (cfg_we) begin
            case (cfg_addr)
                CF_B1:   r_coef[CF_B1] <= cfg_data;
                CF_B2:   r_coef[CF_B2] <= cfg_data;
                CF_B3:   r_coef[CF_B3] <= cfg_data;
                CF_A2:   r_coef[CF_A2] <= cfg_data;
                CF_A3:   r_coef[CF_A3] <= cfg_data;
                default: ;
            endcase
        end
    end

    // Per-channel history; a clear in IDLE precedes the read in LD.
    always_ff @(posedge clk) begin
        if (reset || w_clr_now) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                r_hist_s1[i] <= '0;
                r_hist_s2[i] <= '0;
            end
        end else if (w_hist_we) begin
            r_hist_s1[r_ch] <= r_s1n;
            r_hist_s2[r_ch] <= w_sum;
        end
    end

    // Clear requests seen while busy wait for the next IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_pend <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_clr_pend <= 1'b0;
        end else begin
            r_clr_pend <= r_clr_pend | clr;
        end
    end

    // Per-sample working registers: operands, snapshot and intermediates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x     <= '0;
            r_ch    <= '0;
            r_wcoef <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_y     <= '0;
            r_t     <= '0;
            r_s1n   <= '0;
        end else begin
            if (w_accept) begin
                r_x     <= bus.in_x;
                r_ch    <= bus.in_ch;
                r_wcoef <= r_coef;
            end
            if (w_ld) begin
                r_s1 <= r_hist_s1[r_ch];
                r_s2 <= r_hist_s2[r_ch];
            end
            if (w_y_we) begin
                r_y <= w_y_c;
            end
            if (w_t_we) begin
                r_t <= w_sum;
            end
            if (w_s1n_we) begin
                r_s1n <= w_sum;
            end
        end
    end

    // Registered handshake and status outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_y     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_OUT);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_hist_we) begin
                r_out_ch <= r_ch;
                r_out_y  <= r_y;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_y     = r_out_y;
    assign busy          = r_busy;

endmodule

// File: tb/tb_biquad_channel_scheduler.sv
// Directed, table-driven bench for biquad_channel_scheduler.
module tb_biquad_channel_scheduler;
    import biquad_sched_pkg::*;

    localparam int FRAC_TB = 27;
    localparam int ONE     = 134217728;
    localparam int Y0      = 9426879;
    localparam int Y1      = 16911961;
    localparam int HK_NONE = 0;
    localparam int HK_CFG  = 1;
    localparam int HK_CLR  = 2;
    localparam int NVEC    = 14;

    logic              clk;
    logic              reset;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic signed [31:0] cfg_data;
    logic              clr;
    logic              busy;

    biquad_channel_scheduler_if #(.CHW(3)) bus ();

    biquad_channel_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .clr      (clr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference recurrence.
    longint m_s1 [8];
    longint m_s2 [8];
    int     m_c  [5];

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_s1[i] = 0;
            m_s2[i] = 0;
        end
    endtask

    task automatic model_reset();
        m_c[0] = 9426879;
        m_c[1] = 0;
        m_c[2] = -9426879;
        m_c[3] = -240788605;
        m_c[4] = 115363971;
        model_clear();
    endtask

    task automatic model_step(input int ch, input int x, output int y);
        longint acc;
        longint sh;
        acc = m_s1[ch] + longint'(m_c[0]) * longint'(x);
        sh  = acc >>> FRAC_TB;
`ifdef BIQUAD_SCHED_SAT_EN
        if (sh > 64'sd2147483647) sh = 64'sd2147483647;
        else if (sh < -64'sd2147483648) sh = -64'sd2147483648;
`endif
        y = int'(sh);
        m_s1[ch] = longint'(m_c[1]) * longint'(x) + m_s2[ch] - longint'(m_c[3]) * longint'(y);
        m_s2[ch] = longint'(m_c[2]) * longint'(x) - longint'(m_c[4]) * longint'(y);
    endtask

    // Offer one sample, optionally poke cfg/clr a given number of cycles after acceptance.
    task automatic send(input int ch, input int x, input int hook_kind, input int hook_at,
                        output int y, output int och, output int lat);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (bus.in_ready !== 1'b1) check("in_ready_wait", 0, 1);
        bus.in_valid = 1'b1;
        bus.in_ch    = 3'(ch);
        bus.in_x     = x;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            cfg_we = (hook_kind == HK_CFG) && (lat == hook_at);
            clr    = (hook_kind == HK_CLR) && (lat == hook_at);
        end while (bus.out_valid !== 1'b1 && lat < 40);
        cfg_we = 1'b0;
        clr    = 1'b0;
        if (bus.out_valid !== 1'b1) check("out_valid_wait", 0, 1);
        y   = bus.out_y;
        och = int'(bus.out_ch);
    endtask

    task automatic cfg_write(input logic [2:0] a, input int d);
        cfg_addr = a;
        cfg_data = d;
        cfg_we   = 1'b1;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    task automatic clr_idle();
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    typedef struct {
        int ch;
        int x;
        bit clr_before;
        bit hand;
        int exp_y;
    } vec_t;

    vec_t tbl [NVEC];

    initial begin
        int y, och, lat, ym, g;
        bit saw;
        int ref0 [4];

        // Impulse on ch0, then after a clear the same impulse interleaved with ch1 zeros.
        tbl[0]  = '{0, ONE, 1'b0, 1'b1, Y0};
        tbl[1]  = '{0, 0,   1'b0, 1'b1, Y1};
        tbl[2]  = '{0, 0,   1'b0, 1'b0, 0};
        tbl[3]  = '{0, 0,   1'b0, 1'b0, 0};
        tbl[4]  = '{0, 0,   1'b0, 1'b0, 0};
        tbl[5]  = '{0, 0,   1'b0, 1'b0, 0};
        tbl[6]  = '{0, ONE, 1'b1, 1'b1, Y0};
        tbl[7]  = '{1, 0,   1'b0, 1'b1, 0};
        tbl[8]  = '{0, 0,   1'b0, 1'b1, Y1};
        tbl[9]  = '{1, 0,   1'b0, 1'b1, 0};
        tbl[10] = '{0, 0,   1'b0, 1'b0, 0};
        tbl[11] = '{1, 0,   1'b0, 1'b1, 0};
        tbl[12] = '{0, 0,   1'b0, 1'b0, 0};
        tbl[13] = '{3, -5000000, 1'b0, 1'b0, 0};

        // Fill model-derived expectations; ch0 in the interleaved run must repeat rows 2..3.
        model_reset();
        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].clr_before) model_clear();
            model_step(tbl[i].ch, tbl[i].x, ym);
            if (i >= 2 && i <= 5) ref0[i-2] = ym;
            if (!tbl[i].hand) tbl[i].exp_y = ym;
        end
        tbl[10].exp_y = ref0[0];
        tbl[12].exp_y = ref0[1];

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_x     = '0;
        bus.out_ready = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        clr      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_ch",    bus.out_ch,    0);
        check("rst_out_y",     bus.out_y,     0);
        check("rst_busy",      busy,          0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].clr_before) clr_idle();
            send(tbl[i].ch, tbl[i].x, HK_NONE, 0, y, och, lat);
            check($sformatf("vec%0d_y", i),   y,   tbl[i].exp_y);
            check($sformatf("vec%0d_ch", i),  och, tbl[i].ch);
            check($sformatf("vec%0d_lat", i), lat, 6);
        end

        // Fresh state everywhere for the hand sequences.
        clr_idle();
        model_reset();

        // Backpressure: result held, no acceptance until the handshake.
        bus.out_ready = 1'b0;
        send(5, ONE, HK_NONE, 0, y, och, lat);
        model_step(5, ONE, ym);
        bus.in_valid = 1'b1;
        bus.in_ch    = 3'd6;
        bus.in_x     = ONE;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_valid", k),    bus.out_valid, 1);
            check($sformatf("bp%0d_y", k),        bus.out_y,     Y0);
            check($sformatf("bp%0d_ch", k),       bus.out_ch,    5);
            check($sformatf("bp%0d_in_ready", k), bus.in_ready,  0);
        end
        check("bp_busy", busy, 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 40);
        model_step(6, ONE, ym);
        check("bp_next_lat", lat, 6);
        check("bp_next_y",  bus.out_y,  ym);
        check("bp_next_ch", bus.out_ch, 6);

        // Mid-sample write of b1=0 during P_B2 only affects the following sample.
        cfg_addr = CF_B1;
        cfg_data = 0;
        send(4, ONE, HK_CFG, 2, y, och, lat);
        model_step(4, ONE, ym);
        check("midcfg_cur_y", y, Y0);
        m_c[0] = 0;
        send(7, ONE, HK_NONE, 0, y, och, lat);
        model_step(7, ONE, ym);
        check("midcfg_next_y", y, 0);
        cfg_write(CF_B1, 9426879);
        m_c[0] = 9426879;
        cfg_write(3'd5, 12345);

        // clr while busy: in-flight result intact, writeback cleared afterwards.
        send(2, ONE, HK_NONE, 0, y, och, lat);
        model_step(2, ONE, ym);
        check("clrb_first_y", y, Y0);
        send(2, 0, HK_CLR, 3, y, och, lat);
        model_step(2, 0, ym);
        check("clrb_inflight_y", y, Y1);
        model_clear();
        send(2, ONE, HK_NONE, 0, y, och, lat);
        model_step(2, ONE, ym);
        check("clrb_after_y", y, Y0);
        send(4, 0, HK_NONE, 0, y, och, lat);
        model_step(4, 0, ym);
        check("clrb_other_ch_y", y, 0);

        // Reset during P_A2 aborts the sample and restores coefficients and state.
        cfg_write(CF_B1, ONE);
        send(1, ONE, HK_NONE, 0, y, och, lat);
        check("rst_pre_y", y, ONE);
        g = 0;
        while (bus.in_ready !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        bus.in_valid = 1'b1;
        bus.in_ch    = 3'd1;
        bus.in_x     = ONE;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        saw = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            saw |= bus.out_valid;
        end
        check("rst_mid_in_ready", bus.in_ready, 0);
        check("rst_mid_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_in_ready_after", bus.in_ready, 1);
        repeat (8) begin
            @(posedge clk);
            #1;
            saw |= bus.out_valid;
        end
        check("rst_mid_no_output", saw, 0);
        model_reset();
        send(1, ONE, HK_NONE, 0, y, och, lat);
        model_step(1, ONE, ym);
        check("rst_mid_after_y", y, Y0);
        send(1, 0, HK_NONE, 0, y, och, lat);
        check("rst_mid_after2_y", y, Y1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
